// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO sequencing stage and the signed divider beside it.
package muldiv_hilo_ctrl_pkg;

  localparam int DIV_ITER = 32;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
  } hilo_wr_t;

  function automatic logic is_div_op(input logic op_valid, input logic [1:0] op_code);
    return op_valid && (op_code == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regfile.sv
// Architectural HI/LO registers with independent write enables.
module hilo_regfile
  import muldiv_hilo_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  hilo_wr_t    wr,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (wr.hi_we) hi <= wr.hi_d;
      if (wr.lo_we) lo <= wr.lo_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Launches the external signed divider, waits out its busy window, and retires
// quotient/remainder into LO/HI while stalling the pipeline.
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int          WAIT_MAX = 40,
  parameter logic [31:0] DIV0_LO  = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        kill,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             seen_busy;
  logic             launched;
  logic             done;
  logic             start_q;

  logic     div_op;
  logic     rt_nonzero;
  logic     launch_req;
  logic     wait_exit;
  logic     wait_tmo;
  logic     drain_exit;
  hilo_wr_t wr;

  assign div_op     = is_div_op(op_valid, op_code);
  assign rt_nonzero = (rt_val != '0);
  // A retired DIV re-presented after completion must not launch again.
  assign launch_req = (state == S_IDLE) && div_op && rt_nonzero && !done && !kill;
  assign wait_exit  = (state == S_WAIT) && !kill && !div_busy && seen_busy;
  assign wait_tmo   = (state == S_WAIT) && !kill && !wait_exit &&
                      (wait_cnt == CNT_W'(WAIT_MAX - 1));
  assign drain_exit = (state == S_DRAIN) && !div_busy && (seen_busy || !launched);

  assign stall     = (state != S_IDLE) || launch_req;
  // A kill in LAUNCH suppresses the pulse, so the divider never starts.
  assign div_start = start_q && !kill;

  always_comb begin
    wr = '0;
    if ((state == S_IDLE) && op_valid) begin
      case (op_code)
        OP_MTHI: begin
          wr.hi_we = 1'b1;
          wr.hi_d  = rs_val;
        end
        OP_MTLO: begin
          wr.lo_we = 1'b1;
          wr.lo_d  = rs_val;
        end
        OP_DIV: begin
          if (!rt_nonzero && !kill) begin
            wr.hi_we = 1'b1;
            wr.hi_d  = rs_val;
            wr.lo_we = 1'b1;
            wr.lo_d  = DIV0_LO;
          end
        end
        default: ;
      endcase
    end
    if (wait_exit) begin
      wr.hi_we = 1'b1;
      wr.hi_d  = div_r;
      wr.lo_we = 1'b1;
      wr.lo_d  = div_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      wait_cnt     <= '0;
      seen_busy    <= 1'b0;
      launched     <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid && (op_code != OP_NOP)) done <= 1'b0;
          if (launch_req) begin
            div_dividend <= rs_val;
            div_divisor  <= rt_val;
            start_q      <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          seen_busy <= 1'b0;
          wait_cnt  <= '0;
          launched  <= !kill;
          state     <= kill ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          seen_busy <= seen_busy | div_busy;
          wait_cnt  <= wait_cnt + CNT_W'(1);
          if (kill) begin
            state <= S_DRAIN;
          end else if (wait_exit) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (wait_tmo) begin
            // The aborted op retires too, otherwise the pipeline would relaunch it forever.
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          seen_busy <= seen_busy | div_busy;
          if (drain_exit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  hilo_regfile u_hilo (
    .clock (clock),
    .reset (reset),
    .wr    (wr),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl with a behavioural 32-cycle signed divider beside it.
module tb_muldiv_hilo_ctrl;
  import muldiv_hilo_ctrl_pkg::*;

  localparam int WAIT_MAX = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        kill;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;

  always #5 clock = ~clock;

  muldiv_hilo_ctrl #(.WAIT_MAX(WAIT_MAX), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .kill         (kill),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo),
    .timeout_err  (timeout_err),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  // Divider model: busy for DIV_ITER cycles after the cycle that carries div_start.
  logic hold_low = 1'b0;
  int   busy_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      busy_cnt <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (div_start && !hold_low) begin
      div_q    <= $signed(div_dividend) / $signed(div_divisor);
      div_r    <= $signed(div_dividend) % $signed(div_divisor);
      div_busy <= 1'b1;
      busy_cnt <= DIV_ITER;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) div_busy <= 1'b0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input string tag, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.tag = tag;
    e.hi  = h;
    e.lo  = l;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_hi"}, hi, e.hi);
    check({e.tag, "_lo"}, lo, e.lo);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Holds a DIV until the stall drops, as the pipeline would, then retires it.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input logic [31:0] eh, input logic [31:0] el);
    int st;
    int starts;
    int scyc;
    st = 0; starts = 0; scyc = -1;
    push_exp(tag, eh, el);
    op_valid = 1'b1; op_code = OP_DIV; rs_val = a; rt_val = b;
    @(negedge clock);
    while (stall && st < 200) begin
      if (div_start) begin
        starts++;
        scyc = st;
      end
      st++;
      @(negedge clock);
    end
    if (div_start) starts++;
    check({tag, "_stall_cycles"}, 32'(st), 32'(exp_stall));
    check({tag, "_start_pulses"}, 32'(starts), (exp_stall > 0) ? 32'd1 : 32'd0);
    if (exp_stall > 0) begin
      check({tag, "_start_cycle"}, 32'(scyc), 32'd1);
      pop_check();
    end
    next_cycle();
    op_valid = 1'b0; op_code = OP_NOP;
    @(negedge clock);
    if (exp_stall == 0) pop_check();
    check({tag, "_no_relaunch"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    bit fin;
    int mt_st;

    reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP; rs_val = '0; rt_val = '0; kill = 1'b0;
    #3;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_start", {31'd0, div_start}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    next_cycle();
    do_div("div_100_7", 32'd100, 32'd7, 35, 32'd2, 32'd14);

    next_cycle();
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    next_cycle();
    do_div("div_by0", 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'hFFFF_FFFF);

    // MTHI then MTLO on consecutive cycles
    next_cycle();
    push_exp("mthi", 32'hAAAA_5555, 32'hFFFF_FFFF);
    push_exp("mtlo", 32'hAAAA_5555, 32'h0F0F_0F0F);
    op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'hAAAA_5555;
    @(negedge clock);
    check("mthi_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    op_code = OP_MTLO; rs_val = 32'h0F0F_0F0F;
    @(negedge clock);
    check("mtlo_stall", {31'd0, stall}, 32'd0);
    pop_check();
    next_cycle();
    op_valid = 1'b0; op_code = OP_NOP;
    @(negedge clock);
    pop_check();

    // DIV killed in cycle 10, MTLO offered in cycle 20 while draining
    next_cycle();
    push_exp("kill_hold", 32'hAAAA_5555, 32'h0F0F_0F0F);
    push_exp("kill_mtlo", 32'hAAAA_5555, 32'h5A5A_5A5A);
    fin = 1'b0; mt_st = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 0) begin
        op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
      end
      kill = (c == 10);
      if (c == 11) begin
        op_valid = 1'b0; op_code = OP_NOP;
      end
      if (c == 20) begin
        op_valid = 1'b1; op_code = OP_MTLO; rs_val = 32'h5A5A_5A5A;
      end
      @(negedge clock);
      if (c == 11) check("kill_drain_stall", {31'd0, stall}, 32'd1);
      if (c >= 20) begin
        if (stall) mt_st++;
        else fin = 1'b1;
      end
      if (fin) break;
      next_cycle();
    end
    check("kill_mtlo_accepted", {31'd0, fin}, 32'd1);
    check("kill_mtlo_stalls", 32'(mt_st), 32'd15);
    pop_check();
    next_cycle();
    op_valid = 1'b0; op_code = OP_NOP;
    @(negedge clock);
    pop_check();

    // Reset asserted mid-division
    next_cycle();
    op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    repeat (15) next_cycle();
    #2;
    reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_start", {31'd0, div_start}, 32'd0);
    check("midrst_dividend", div_dividend, 32'd0);
    check("midrst_divisor", div_divisor, 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    do_div("div_9_3", 32'd9, 32'd3, 35, 32'd0, 32'd3);

    // Divider never raises busy: WAIT_MAX abort
    next_cycle();
    check("tmo_before", {31'd0, timeout_err}, 32'd0);
    hold_low = 1'b1;
    do_div("tmo", 32'd100, 32'd7, WAIT_MAX + 2, 32'd0, 32'd3);
    check("tmo_after", {31'd0, timeout_err}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
